// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and datapath:
// opcode/funct codes, ALU control codes, mux selects and FSM state encoding.
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU control codes, shared with the datapath ALU
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b100;
    localparam logic [2:0] ALUCTL_MUL = 3'b101;
    localparam logic [2:0] ALUCTL_SLT = 3'b110;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // Values 12-15 are unreachable and recover to S_FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_IMM   = 2'd3
    } aluop_t;

    // Per-state control word before reset gating and the PCEn combine
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic       alu_en;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       branchne;
        logic       instrdone;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU-op class plus Funct/Op
// to the 3-bit ALUControl, and flags whether an R-type Funct is known.
module mips_alu_decoder
    import mips_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  aluop_t     AluOp,
    input  logic [5:0] Funct,
    input  logic [5:0] Op,
    output logic [2:0] ALUControl,
    output logic       FunctValid
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        ALUControl = ALUCTL_ADD;
        FunctValid = 1'b0;
        case (AluOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                // Unknown Funct executes as a NOP, so drive a quiet code
                ALUControl = ALUCTL_AND;
                FunctValid = 1'b1;
                case (Funct)
                    FUNCT_ADD: ALUControl = ALUCTL_ADD;
                    FUNCT_SUB: ALUControl = ALUCTL_SUB;
                    FUNCT_AND: ALUControl = ALUCTL_AND;
                    FUNCT_OR:  ALUControl = ALUCTL_OR;
                    FUNCT_SLT: ALUControl = ALUCTL_SLT;
                    FUNCT_MUL: begin
                        if (ENABLE_MUL) ALUControl = ALUCTL_MUL;
                        else            FunctValid = 1'b0;
                    end
                    default:   FunctValid = 1'b0;
                endcase
            end
            ALUOP_IMM: begin
                case (Op)
                    OP_ANDI: ALUControl = ALUCTL_AND;
                    OP_ORI:  ALUControl = ALUCTL_OR;
                    OP_SLTI: ALUControl = ALUCTL_SLT;
                    default: ALUControl = ALUCTL_ADD;
                endcase
            end
            default: ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM on Op driving every datapath
// select/strobe, with an ALU decoder and the PCEn branch gate.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZext,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       InstrDone,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl;
    aluop_t     aluop;
    logic [2:0] dec_alu;
    logic       funct_valid;
    logic       is_bne;
    logic       is_itype;

    assign is_bne   = ENABLE_BNE && (Op == OP_BNE);
    assign is_itype = (Op == OP_ADDI) || (Op == OP_ANDI) ||
                      (Op == OP_ORI)  || (Op == OP_SLTI);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    // ALU-op class depends on state alone, kept apart from the next-state block
    always_comb begin
        case (state)
            S_EXEC:   aluop = ALUOP_FUNCT;
            S_BRANCH: aluop = ALUOP_SUB;
            S_IEXEC:  aluop = ALUOP_IMM;
            default:  aluop = ALUOP_ADD;
        endcase
    end

    mips_alu_decoder #(
        .ENABLE_MUL (ENABLE_MUL)
    ) u_alu_decoder (
        .AluOp      (aluop),
        .Funct      (Funct),
        .Op         (Op),
        .ALUControl (dec_alu),
        .FunctValid (funct_valid)
    );

    always_comb begin
        ctrl       = '0;
        state_next = S_FETCH;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.alu_en  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALURESULT;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_BRANCH;
                ctrl.alu_en  = 1'b1;
                if (Op == OP_LW || Op == OP_SW)      state_next = S_MEMADR;
                else if (Op == OP_RTYPE)             state_next = S_EXEC;
                else if (Op == OP_BEQ || is_bne)     state_next = S_BRANCH;
                else if (is_itype)                   state_next = S_IEXEC;
                else if (Op == OP_J)                 state_next = S_JUMP;
                else                                 state_next = S_FETCH;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.alu_en  = 1'b1;
                if (Op == OP_LW)      state_next = S_MEMRD;
                else if (Op == OP_SW) state_next = S_MEMWR;
                else                  state_next = S_FETCH;
            end
            S_MEMRD: begin
                ctrl.iord  = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.memtoreg  = 1'b1;
                ctrl.regwrite  = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.memwrite  = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.alu_en  = 1'b1;
                if (funct_valid) state_next = S_ALUWB;
                else             ctrl.instrdone = 1'b1;
            end
            S_ALUWB: begin
                ctrl.regdst    = 1'b1;
                ctrl.regwrite  = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alu_en    = 1'b1;
                ctrl.pcsrc     = PCSRC_ALUOUT;
                ctrl.branch    = (Op == OP_BEQ);
                ctrl.branchne  = is_bne;
                ctrl.instrdone = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.alu_en  = 1'b1;
                ctrl.immzext = (Op == OP_ANDI) || (Op == OP_ORI);
                state_next   = S_IWB;
            end
            S_IWB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc     = PCSRC_JUMP;
                ctrl.pcwrite   = 1'b1;
                ctrl.instrdone = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // NOTE: rst_n gates every output combinationally, so strobes drop the instant reset asserts.
    assign IorD       = rst_n & ctrl.iord;
    assign MemWrite   = rst_n & ctrl.memwrite;
    assign IRWrite    = rst_n & ctrl.irwrite;
    assign RegDst     = rst_n & ctrl.regdst;
    assign MemtoReg   = rst_n & ctrl.memtoreg;
    assign RegWrite   = rst_n & ctrl.regwrite;
    assign ALUSrcA    = rst_n & ctrl.alusrca;
    assign ALUSrcB    = rst_n ? ctrl.alusrcb : 2'b00;
    assign ImmZext    = rst_n & ctrl.immzext;
    assign ALUControl = (rst_n && ctrl.alu_en) ? dec_alu : 3'b000;
    assign PCSrc      = rst_n ? ctrl.pcsrc : 2'b00;
    assign PCEn       = rst_n & (ctrl.pcwrite | (ctrl.branch & Zero) | (ctrl.branchne & ~Zero));
    assign InstrDone  = rst_n & ctrl.instrdone;
    assign state_o    = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected output traces built from the
// instruction's class, compared cycle by cycle against two controller variants.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [2:0] aluctl;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       instrdone;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op    = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero  = 1'b0;

    logic       iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0, immzext0, pcen0, done0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] aluctl0;
    logic [3:0] state0;
    logic       iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1, immzext1, pcen1, done1;
    logic [1:0] alusrcb1, pcsrc1;
    logic [2:0] aluctl1;
    logic [3:0] state1;

    vec_t obs0, obs1;
    assign obs0 = {state0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0,
                   alusrca0, alusrcb0, immzext0, aluctl0, pcsrc0, pcen0, done0};
    assign obs1 = {state1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1,
                   alusrca1, alusrcb1, immzext1, aluctl1, pcsrc1, pcen1, done1};

    mips_multicycle_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .Zero(zero),
        .IorD(iord0), .MemWrite(memwrite0), .IRWrite(irwrite0), .RegDst(regdst0),
        .MemtoReg(memtoreg0), .RegWrite(regwrite0), .ALUSrcA(alusrca0), .ALUSrcB(alusrcb0),
        .ImmZext(immzext0), .ALUControl(aluctl0), .PCSrc(pcsrc0), .PCEn(pcen0),
        .InstrDone(done0), .state_o(state0)
    );

    mips_multicycle_ctrl #(.ENABLE_MUL(1'b0), .ENABLE_BNE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .Zero(zero),
        .IorD(iord1), .MemWrite(memwrite1), .IRWrite(irwrite1), .RegDst(regdst1),
        .MemtoReg(memtoreg1), .RegWrite(regwrite1), .ALUSrcA(alusrca1), .ALUSrcB(alusrcb1),
        .ImmZext(immzext1), .ALUControl(aluctl1), .PCSrc(pcsrc1), .PCEn(pcen1),
        .InstrDone(done1), .state_o(state1)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t exp_q[$];

    function automatic vec_t blank(input int st);
        vec_t c;
        c       = '0;
        c.state = st[3:0];
        return c;
    endfunction

    // Returns {known, alu code} for an R-type function field
    function automatic logic [3:0] funct_alu(input logic [5:0] f, input bit en_mul);
        case (f)
            6'h20:   return {1'b1, 3'b010};
            6'h22:   return {1'b1, 3'b100};
            6'h24:   return {1'b1, 3'b000};
            6'h25:   return {1'b1, 3'b001};
            6'h2A:   return {1'b1, 3'b110};
            6'h18:   return en_mul ? {1'b1, 3'b101} : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    // Reference model: the full per-cycle output trace of one instruction, FETCH onward
    task automatic build_expected(input logic [5:0] o, input logic [5:0] f, input logic z,
                                  input bit en_bne, input bit en_mul);
        vec_t       c;
        logic [3:0] fa;
        exp_q.delete();
        c = blank(0); c.alusrcb = 2'b01; c.aluctl = 3'b010; c.irwrite = 1; c.pcen = 1; exp_q.push_back(c);
        c = blank(1); c.alusrcb = 2'b11; c.aluctl = 3'b010; exp_q.push_back(c);
        if (o == 6'b100011 || o == 6'b101011) begin
            c = blank(2); c.alusrca = 1; c.alusrcb = 2'b10; c.aluctl = 3'b010; exp_q.push_back(c);
            if (o == 6'b100011) begin
                c = blank(3); c.iord = 1; exp_q.push_back(c);
                c = blank(4); c.memtoreg = 1; c.regwrite = 1; c.instrdone = 1; exp_q.push_back(c);
            end else begin
                c = blank(5); c.iord = 1; c.memwrite = 1; c.instrdone = 1; exp_q.push_back(c);
            end
        end else if (o == 6'b000000) begin
            fa = funct_alu(f, en_mul);
            c = blank(6); c.alusrca = 1; c.aluctl = fa[2:0]; c.instrdone = ~fa[3]; exp_q.push_back(c);
            if (fa[3]) begin
                c = blank(7); c.regdst = 1; c.regwrite = 1; c.instrdone = 1; exp_q.push_back(c);
            end
        end else if (o == 6'b000100 || (o == 6'b000101 && en_bne)) begin
            c = blank(8); c.alusrca = 1; c.aluctl = 3'b100; c.pcsrc = 2'b01; c.instrdone = 1;
            c.pcen = (o == 6'b000100) ? z : ~z;
            exp_q.push_back(c);
        end else if (o == 6'b001000 || o == 6'b001100 || o == 6'b001101 || o == 6'b001010) begin
            c = blank(9); c.alusrca = 1; c.alusrcb = 2'b10;
            case (o)
                6'b001100: begin c.aluctl = 3'b000; c.immzext = 1; end
                6'b001101: begin c.aluctl = 3'b001; c.immzext = 1; end
                6'b001010: c.aluctl = 3'b110;
                default:   c.aluctl = 3'b010;
            endcase
            exp_q.push_back(c);
            c = blank(10); c.regwrite = 1; c.instrdone = 1; exp_q.push_back(c);
        end else if (o == 6'b000010) begin
            c = blank(11); c.pcsrc = 2'b10; c.pcen = 1; c.instrdone = 1; exp_q.push_back(c);
        end
    endtask

    task automatic check(input string tag, input bit which, input vec_t expv);
        vec_t o;
        o = which ? obs1 : obs0;
        vectors++;
        assert (o === expv) else begin
            miscompares++;
            $error("FAIL %s: observed state=%0d word=%h, expected state=%0d word=%h",
                   tag, o.state, o, expv.state, expv);
        end
    endtask

    // Entered one tick after a rising edge with the DUT in FETCH; leaves it the same way
    task automatic run_instr(input string tag, input bit which, input logic [5:0] o,
                             input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
        build_expected(o, f, z, !which, !which);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), which, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000,
                                   6'b001010, 6'b001100, 6'b001101, 6'b100011, 6'b101011};
    logic [5:0] known_fn  [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00};

    initial begin
        logic [5:0] ro, rf;
        logic       rz;

        // Power-on reset: everything low
        #2 check("reset_hold", 0, blank(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while in MEMRD of a lw
        op = 6'b100011; funct = 6'h00; zero = 1'b0;
        build_expected(op, funct, zero, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check($sformatf("lw_pre_reset[%0d]", i), 0, exp_q[i]);
            @(posedge clk); #1;
        end
        @(negedge clk); check("lw_memrd", 0, exp_q[3]);
        #1 rst_n = 1'b0;
        #1 check("reset_same_cycle", 0, blank(0));
        @(posedge clk); #1 check("reset_across_edge", 0, blank(0));
        rst_n = 1'b1;

        // Directed instructions
        run_instr("lw",        0, 6'b100011, 6'h00, 1'b1);
        run_instr("sw",        0, 6'b101011, 6'h00, 1'b0);
        run_instr("r_sub",     0, 6'b000000, 6'h22, 1'b0);
        run_instr("r_slt",     0, 6'b000000, 6'h2A, 1'b1);
        run_instr("r_mul",     0, 6'b000000, 6'h18, 1'b0);
        run_instr("r_and",     0, 6'b000000, 6'h24, 1'b0);
        run_instr("r_nop",     0, 6'b000000, 6'h00, 1'b1);
        run_instr("beq_taken", 0, 6'b000100, 6'h00, 1'b1);
        run_instr("beq_not",   0, 6'b000100, 6'h00, 1'b0);
        run_instr("bne_taken", 0, 6'b000101, 6'h00, 1'b0);
        run_instr("bne_not",   0, 6'b000101, 6'h00, 1'b1);
        run_instr("ori",       0, 6'b001101, 6'h00, 1'b0);
        run_instr("j",         0, 6'b000010, 6'h00, 1'b1);
        run_instr("undef_op",  0, 6'b111111, 6'h20, 1'b0);

        // Randomised instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) ro = 6'($urandom);
            else                           ro = legal_ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 0) rf = known_fn[$urandom_range(0, 6)];
            else                           rf = 6'($urandom);
            rz = 1'($urandom);
            run_instr($sformatf("rand%0d_op%h_fn%h", n, ro, rf), 0, ro, rf, rz);
        end

        // Variant without bne and mul
        rst_n = 1'b0;
        @(negedge clk); check("nobne_reset", 1, blank(0));
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr("nobne_bne",   1, 6'b000101, 6'h00, 1'b0);
        run_instr("nomul_mul",   1, 6'b000000, 6'h18, 1'b0);
        run_instr("nomul_add",   1, 6'b000000, 6'h20, 1'b1);
        run_instr("nobne_beq",   1, 6'b000100, 6'h00, 1'b1);
        run_instr("nobne_undef", 1, 6'b111111, 6'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
